// File: rtl/mul_tc_seq.sv
// Radix-2 shift-add multiplier, one b bit per clock, signed or unsigned per transaction.
// Latency B_W cycles accept-to-out_valid; single transaction in flight, in_ready only in IDLE.
module mul_tc_seq #(
  parameter int A_W = 16,
  parameter int B_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  input  logic                 tc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_W+B_W-1:0]   product
);

  localparam int P_W = A_W + B_W;
  localparam int CW  = $clog2(B_W);
  localparam logic [CW-1:0] LAST = CW'(B_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic [P_W-1:0] r_a_sh;
  logic [B_W-1:0] r_b;
  logic           r_tc;
  logic [P_W-1:0] r_acc;
  logic [P_W-1:0] r_product;

  logic           w_last;
  logic [P_W-1:0] w_term;
  logic [P_W-1:0] w_sum;

  // The sign bit of b carries weight -2^(B_W-1) in two's complement.
  always_comb begin
    w_last = (r_cnt == LAST);
    w_term = r_b[0] ? r_a_sh : '0;
    w_sum  = (r_tc && w_last) ? (r_acc - w_term) : (r_acc + w_term);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_a_sh    <= '0;
      r_b       <= '0;
      r_tc      <= 1'b0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh  <= tc ? {{B_W{a[A_W-1]}}, a} : {{B_W{1'b0}}, a};
            r_b     <= b;
            r_tc    <= tc;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc  <= w_sum;
          r_a_sh <= r_a_sh << 1;
          r_b    <= r_b >> 1;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_product <= w_sum;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign product   = r_product;

endmodule

// File: tb/tb_mul_tc_seq.sv
// Directed bench for mul_tc_seq: default 16x16 instance plus an 8x4 instance checked against a model.
module tb_mul_tc_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv16, ir16, tc16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic        iv8, ir8, tc8, ov8, or8;
  logic [7:0]  a8;
  logic [3:0]  b8;
  logic [11:0] p8;

  mul_tc_seq u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .tc(tc16),
    .out_valid(ov16), .out_ready(or16), .product(p16)
  );

  mul_tc_seq #(.A_W(8), .B_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .tc(tc8),
    .out_valid(ov8), .out_ready(or8), .product(p8)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Edge counter and acceptance log for the 16-bit instance.
  int cyc = 0;
  int acc16 = 0;
  int last_acc16 = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (iv16 && ir16 && !rst) begin
      acc16      <= acc16 + 1;
      last_acc16 <= cyc;
    end
  end

  task automatic accept16();
    int n;
    n = 0;
    while (!ir16 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("ir16_timeout", {63'd0, ir16}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_ov16(output int lat);
    lat = 0;
    while (!ov16 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) check("ov16_timeout", {63'd0, ov16}, 64'd1);
  endtask

  task automatic run16(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic t, input logic [31:0] exp);
    int lat;
    a16 = x; b16 = y; tc16 = t; iv16 = 1'b1;
    accept16();
    iv16 = 1'b0;
    wait_ov16(lat);
    check({tag, "_lat"}, 64'(lat), 64'd16);
    check(tag, 64'(p16), 64'(exp));
    @(posedge clk); #1;
  endtask

  function automatic logic [11:0] ref8(input logic [7:0] x, input logic [3:0] y, input logic t);
    int sx, sy, p;
    sx = t ? int'($signed(x)) : int'(x);
    sy = t ? int'($signed(y)) : int'(y);
    p  = sx * sy;
    return p[11:0];
  endfunction

  task automatic run8(input string tag, input logic [7:0] x, input logic [3:0] y,
                      input logic t, input logic [11:0] exp);
    int lat;
    a8 = x; b8 = y; tc8 = t; iv8 = 1'b1;
    lat = 0;
    while (!ir8 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check(tag, 64'(p8), 64'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, first, acc_before, bad, hi;
    logic [7:0] rx;
    logic [3:0] ry;
    logic       rt;

    rst = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; tc16 = 1'b0; or16 = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; tc8 = 1'b0; or8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", {63'd0, ir16}, 64'd1);
    check("rst_out_valid", {63'd0, ov16}, 64'd0);
    check("rst_product", 64'(p16), 64'd0);
    check("rst_in_ready8", {63'd0, ir8}, 64'd1);

    // Most-negative squared, with handoff timing.
    a16 = 16'h8000; b16 = 16'h8000; tc16 = 1'b1; iv16 = 1'b1;
    accept16();
    iv16 = 1'b0;
    wait_ov16(lat);
    check("minneg_lat", 64'(lat), 64'd16);
    check("minneg_prod", 64'(p16), 64'h4000_0000);
    check("minneg_busy", {63'd0, ir16}, 64'd0);
    @(posedge clk); #1;
    check("handoff_ov", {63'd0, ov16}, 64'd0);
    check("handoff_ir", {63'd0, ir16}, 64'd1);
    check("handoff_hold", 64'(p16), 64'h4000_0000);

    run16("ffff_u", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    run16("ffff_s", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);

    // Back-to-back with in_valid held; second pair must wait for in_ready.
    a16 = 16'hFFFD; b16 = 16'd7; tc16 = 1'b1; iv16 = 1'b1;
    acc_before = acc16;
    accept16();
    first = last_acc16;
    a16 = 16'd5; b16 = 16'd0;
    wait_ov16(lat);
    check("b2b1_lat", 64'(lat), 64'd16);
    check("b2b1_prod", 64'(p16), 64'hFFFF_FFEB);
    check("b2b_not_consumed", 64'(acc16 - acc_before), 64'd1);
    @(posedge clk); #1;
    accept16();
    iv16 = 1'b0;
    check("b2b_interval", 64'(last_acc16 - first), 64'd18);
    wait_ov16(lat);
    check("b2b2_lat", 64'(lat), 64'd16);
    check("b2b2_prod", 64'(p16), 64'd0);
    @(posedge clk); #1;

    // Backpressure: hold DONE for 10 cycles with a new pair queued.
    or16 = 1'b0;
    a16 = 16'h1234; b16 = 16'd2; tc16 = 1'b0; iv16 = 1'b1;
    accept16();
    a16 = 16'h0010; b16 = 16'h0010;
    wait_ov16(lat);
    check("bp_prod", 64'(p16), 64'h2468);
    acc_before = acc16;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ov16 !== 1'b1 || ir16 !== 1'b0 || p16 !== 32'h2468) bad++;
    end
    check("bp_stable", 64'(bad), 64'd0);
    check("bp_not_consumed", 64'(acc16 - acc_before), 64'd0);
    or16 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ov", {63'd0, ov16}, 64'd0);
    accept16();
    iv16 = 1'b0;
    check("bp_queued_accept", 64'(acc16 - acc_before), 64'd1);
    wait_ov16(lat);
    check("bp_queued_prod", 64'(p16), 64'h100);
    @(posedge clk); #1;

    // Reset with counter at 5 aborts the transaction.
    a16 = 16'd7; b16 = 16'd9; tc16 = 1'b0; iv16 = 1'b1;
    accept16();
    iv16 = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ov", {63'd0, ov16}, 64'd0);
    check("abort_prod", 64'(p16), 64'd0);
    check("abort_ir", {63'd0, ir16}, 64'd1);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ov16) hi++;
    end
    check("abort_no_stale", 64'(hi), 64'd0);
    run16("recover", 16'd7, 16'd9, 1'b0, 32'd63);

    // Narrow instance: directed corners then random pairs.
    run8("n8_minneg", 8'h80, 4'h8, 1'b1, 12'h400);
    run8("n8_ff_u", 8'hFF, 4'hF, 1'b0, 12'hEF1);
    run8("n8_ff_s", 8'hFF, 4'hF, 1'b1, 12'h001);
    run8("n8_mix_s", 8'h7F, 4'h8, 1'b1, 12'hC08);
    for (int i = 0; i < 24; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 4'($urandom_range(0, 15));
      rt = 1'($urandom_range(0, 1));
      run8("n8_rand", rx, ry, rt, ref8(rx, ry, rt));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
